mux_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one registered 2:1 BITS-wide mux datapath between two requesters, A and B.
- Sequences the mux select and enable from a 3-state FSM, with a burst counter that bounds how long one side can hold the datapath.
- Sits in front of the ACT-cell registered-mux datapath.
- Provides a per-requester req/ack handshake and a valid-tagged registered output.

---
 rtl/mux_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mux_share_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter
//   Round-robin arbiter sharing one registered 2:1 mux datapath between two
//   requesters, A and B. A three-state FSM (IDLE / SERVE_A / SERVE_B) drives
//   the mux select and enable. A burst counter limits how many consecutive
//   transfers one side may make while the other side is waiting.
//
// Parameters
//   BITS       data width of each requester and of the output register
//   MAX_BURST  max consecutive transfers per grant while the other side waits (1..15)
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   req_a      requester A has valid data on data_a
//   data_a     requester A data
//   ack_a      combinational; data_a is captured at this rising edge
//   req_b      requester B has valid data on data_b
//   data_b     requester B data
//   ack_b      combinational; data_b is captured at this rising edge
//   out        registered mux output
//   out_valid  registered; one-cycle pulse after each capture
//   out_src    registered; source of the current out value (0=A, 1=B)
//   busy       FSM is not in IDLE
module mux_share_arbiter #(
  parameter int BITS      = 3,
  parameter int MAX_BURST = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_a,
  input  logic [BITS-1:0] data_a,
  output logic            ack_a,
  input  logic            req_b,
  input  logic [BITS-1:0] data_b,
  output logic            ack_b,
  output logic [BITS-1:0] out,
  output logic            out_valid,
  output logic            out_src,
  output logic            busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  state_t        other_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_inc;
  logic          last;
  logic          last_next;
  logic          sel;
  logic          en;
  logic          own_req;
  logic          other_req;

  // Handshake and datapath control are pure decodes of the current state.
  // A requester only ever sees an ack while its own SERVE state is active,
  // so the two acks can never be high together.
  always_comb begin
    ack_a = (state == SERVE_A) & req_a;
    ack_b = (state == SERVE_B) & req_b;
    sel   = (state == SERVE_B);
    en    = ack_a | ack_b;
    busy  = (state != IDLE);
  end

  // Next-state logic. In either SERVE state the rules are symmetric, so the
  // "own" and "other" sides are selected by sel and a single set of rules is
  // written once. last records the most recently granted side (1 = B), which
  // decides a tie from IDLE in favour of the other side.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    last_next   = last;
    cnt_inc     = cnt + CW'(1);
    own_req     = sel ? req_b : req_a;
    other_req   = sel ? req_a : req_b;
    other_state = sel ? SERVE_A : SERVE_B;

    case (state)
      IDLE: begin
        if (req_a && (!req_b || last)) begin
          state_next = SERVE_A;
          last_next  = 1'b0;
          cnt_next   = '0;
        end else if (req_b) begin
          state_next = SERVE_B;
          last_next  = 1'b1;
          cnt_next   = '0;
        end
      end

      SERVE_A, SERVE_B: begin
        if (!own_req) begin
          // Owner released: hand over with no transfer this cycle.
          cnt_next = '0;
          if (other_req) begin
            state_next = other_state;
            last_next  = ~sel;
          end else begin
            state_next = IDLE;
          end
        end else if (cnt_inc == BURST_END) begin
          // Final transfer of the burst window still completes at this edge.
          // With nobody waiting, the window simply restarts.
          cnt_next = '0;
          if (other_req) begin
            state_next = other_state;
            last_next  = ~sel;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state, burst counter and priority bookkeeping. Reset leaves A with
  // first priority by pretending B was the last side served.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      last  <= last_next;
    end
  end

  // Registered mux. out and out_src hold between transfers while out_valid
  // marks the single cycle following each capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_src   <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        out     <= sel ? data_b : data_a;
        out_src <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter
//   Directed bench for mux_share_arbiter with default parameters
//   (BITS=3, MAX_BURST=4). Inputs change 1 time unit after a rising edge,
//   and outputs are sampled away from the edge.
module tb_mux_share_arbiter;

  logic       clock;
  logic       reset;
  logic       req_a;
  logic [2:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [2:0] data_b;
  logic       ack_b;
  logic [2:0] out;
  logic       out_valid;
  logic       out_src;
  logic       busy;

  int checks;
  int errors;

  logic       pa;
  logic       pb;
  logic [2:0] exp_a;

  // Contention sequence A1..A4, B6..B9, A5 with 3-bit wraparound on B.
  logic [2:0] exp_out [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0, 3'd1, 3'd5};
  logic       exp_src [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  mux_share_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .out       (out),
    .out_valid (out_valid),
    .out_src   (out_src),
    .busy      (busy)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ra, input logic [2:0] da,
                               input logic rb, input logic [2:0] db);
    req_a  = ra;
    data_a = da;
    req_b  = rb;
    data_b = db;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    data_a = 3'd0;
    data_b = 3'd0;
    #2;

    // Reset held with both sides requesting.
    reset = 1'b0;
    applyStimulus(1'b1, 3'd0, 1'b1, 3'd0);
    step();
    step();
    checkOutput("rst_out",       8'(out),       8'd0);
    checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
    checkOutput("rst_out_src",   8'(out_src),   8'd0);
    checkOutput("rst_ack_a",     8'(ack_a),     8'd0);
    checkOutput("rst_ack_b",     8'(ack_b),     8'd0);
    checkOutput("rst_busy",      8'(busy),      8'd0);

    // Release: A granted on the first edge, ack_a visible in the 2nd cycle.
    reset = 1'b1;
    #1;
    checkOutput("rel_ack_a_c1", 8'(ack_a), 8'd0);
    step();
    checkOutput("rel_ack_a_c2", 8'(ack_a), 8'd1);
    checkOutput("rel_ack_b_c2", 8'(ack_b), 8'd0);
    checkOutput("rel_busy",     8'(busy),  8'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    step();
    checkOutput("rel_idle_busy",  8'(busy),      8'd0);
    checkOutput("rel_idle_valid", 8'(out_valid), 8'd0);

    // Single requester: data 5 from A.
    applyStimulus(1'b1, 3'd5, 1'b0, 3'd0);
    checkOutput("single_ack_c0", 8'(ack_a), 8'd0);
    step();
    checkOutput("single_ack_c1", 8'(ack_a), 8'd1);
    step();
    checkOutput("single_out",       8'(out),       8'd5);
    checkOutput("single_out_src",   8'(out_src),   8'd0);
    checkOutput("single_out_valid", 8'(out_valid), 8'd1);
    applyStimulus(1'b0, 3'd5, 1'b0, 3'd0);
    step();
    checkOutput("single_valid_drop", 8'(out_valid), 8'd0);
    checkOutput("single_out_hold",   8'(out),       8'd5);
    checkOutput("single_idle",       8'(busy),      8'd0);

    // Early release: A makes two transfers, then drops with B waiting.
    applyStimulus(1'b1, 3'd1, 1'b0, 3'd6);
    step();
    checkOutput("early_ack_a", 8'(ack_a), 8'd1);
    step();
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd6);
    checkOutput("early_out1", 8'(out), 8'd1);
    step();
    checkOutput("early_out2",   8'(out),       8'd2);
    checkOutput("early_valid2", 8'(out_valid), 8'd1);
    applyStimulus(1'b0, 3'd3, 1'b1, 3'd6);
    checkOutput("early_gap_ack_a", 8'(ack_a), 8'd0);
    checkOutput("early_gap_ack_b", 8'(ack_b), 8'd0);
    checkOutput("early_gap_busy",  8'(busy),  8'd1);
    step();
    checkOutput("early_gap_valid", 8'(out_valid), 8'd0);
    checkOutput("early_gap_hold",  8'(out),       8'd2);
    checkOutput("early_ack_b",     8'(ack_b),     8'd1);
    applyStimulus(1'b0, 3'd3, 1'b0, 3'd6);
    step();
    checkOutput("early_back_idle", 8'(busy), 8'd0);

    // Tie from IDLE after B was last granted: A must win.
    applyStimulus(1'b1, 3'd1, 1'b1, 3'd6);
    checkOutput("tie_idle_ack", 8'(ack_a), 8'd0);
    step();
    checkOutput("tie_ack_a", 8'(ack_a), 8'd1);
    checkOutput("tie_ack_b", 8'(ack_b), 8'd0);

    // Contention with MAX_BURST=4: gap-free A1..A4, B6..B9, A5.
    for (int i = 0; i < 9; i++) begin
      pa = ack_a;
      pb = ack_b;
      checkOutput($sformatf("cont_excl_%0d", i), 8'(pa & pb), 8'd0);
      step();
      if (pa) data_a = data_a + 3'd1;
      if (pb) data_b = data_b + 3'd1;
      checkOutput($sformatf("cont_valid_%0d", i), 8'(out_valid), 8'd1);
      checkOutput($sformatf("cont_out_%0d", i),   8'(out),       8'(exp_out[i]));
      checkOutput($sformatf("cont_src_%0d", i),   8'(out_src),   8'(exp_src[i]));
    end

    // Solo long burst: A alone for 10 transfers, burst window wraps in place.
    req_b = 1'b0;
    #1;
    exp_a = 3'd6;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("solo_ack_a_%0d", i), 8'(ack_a), 8'd1);
      checkOutput($sformatf("solo_ack_b_%0d", i), 8'(ack_b), 8'd0);
      step();
      data_a = data_a + 3'd1;
      checkOutput($sformatf("solo_valid_%0d", i), 8'(out_valid), 8'd1);
      checkOutput($sformatf("solo_out_%0d", i),   8'(out),       8'(exp_a));
      checkOutput($sformatf("solo_src_%0d", i),   8'(out_src),   8'd0);
      exp_a = exp_a + 3'd1;
    end

    // Mid-burst reset while B holds the datapath.
    req_a = 1'b0;
    req_b = 1'b1;
    #1;
    checkOutput("mid_ack_a_drop", 8'(ack_a), 8'd0);
    step();
    checkOutput("mid_ack_b", 8'(ack_b), 8'd1);
    step();
    checkOutput("mid_out_b",   8'(out),     8'd2);
    checkOutput("mid_src_b",   8'(out_src), 8'd1);
    checkOutput("mid_ack_b_2", 8'(ack_b),   8'd1);
    data_b = data_b + 3'd1;
    req_a  = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_out",   8'(out),       8'd0);
    checkOutput("mid_rst_valid", 8'(out_valid), 8'd0);
    checkOutput("mid_rst_src",   8'(out_src),   8'd0);
    checkOutput("mid_rst_ack_b", 8'(ack_b),     8'd0);
    checkOutput("mid_rst_busy",  8'(busy),      8'd0);
    step();
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_idle", 8'(ack_a), 8'd0);
    step();
    checkOutput("mid_rel_ack_a", 8'(ack_a), 8'd1);
    checkOutput("mid_rel_ack_b", 8'(ack_b), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
